seven_seg_scan_driver: RTL and testbench

//  Downstream display stage for the FSM/ALU/register/memory top level.

---
 rtl/seven_seg_scan_driver_pkg.sv | 29 ++
 rtl/seven_seg_scan_driver_if.sv | 8 +
 rtl/seven_seg_scan_driver_hex.sv | 12 +
 rtl/seven_seg_scan_driver.sv | 72 +++++++
 tb/tb_seven_seg_scan_driver.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// seven_seg_scan_driver_pkg: display geometry, hex glyphs and the leading-digit finder
package seven_seg_scan_driver_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W = 4;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [2:0] msd_of(input logic [31:0] w);
    logic [2:0] m;
    m = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (w[NIBBLE_W*k +: NIBBLE_W] != '0) m = 3'(k);
    return m;
  endfunction
endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: valid/ready word handshake between producer and display driver
interface seven_seg_scan_driver_if;
  logic [31:0] data_in;
  logic data_valid;
  logic data_ready;
  modport master (output data_in, data_valid, input data_ready);
  modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/seven_seg_scan_driver_hex.sv
// hex_to_seven_seg: combinational nibble to active-low {g,f,e,d,c,b,a} glyph
module hex_to_seven_seg
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  localparam logic [6:0] GLYPH [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                       SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  // table lookup of the glyph
  always_comb seg = GLYPH[nib];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: frame-synchronous 8-digit multiplexed hex display driver
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter logic [6:0] BLANK_CODE = 7'h7F
) (
  input  logic clk,
  input  logic reset,
  seven_seg_scan_driver_if.slave bus,
  input  logic blank_lz,
  output logic [6:0] segment,
  output logic [7:0] digit,
  output logic frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0] idx_q, idx_d;
  logic [31:0] pend_q, pend_d, shadow_q, shadow_d;
  logic pend_full_q, pend_full_d, ready_q, ready_d;
  logic [6:0] segment_q, segment_d, glyph;
  logic [7:0] digit_q, digit_d;
  logic frame_done_q, frame_done_d;
  logic tick, wrap, xfer, take, blanked;
  hex_to_seven_seg u_hex (.nib(shadow_q[{idx_q, 2'b00} +: NIBBLE_W]), .seg(glyph));
  // next state: the shadow only swaps on the wrap tick, so a frame never mixes two words
  always_comb begin
    tick = presc_q == LAST;
    wrap = tick && idx_q == 3'(NUM_DIGITS - 1);
    xfer = bus.data_valid && ready_q;
    take = wrap && pend_full_q;
    blanked = blank_lz && idx_q > msd_of(shadow_q);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d = tick ? idx_q + 3'd1 : idx_q;
    pend_d = xfer ? bus.data_in : pend_q;
    pend_full_d = xfer || (pend_full_q && !take);
    shadow_d = take ? pend_q : shadow_q;
    ready_d = !pend_full_d;
    digit_d = blanked ? 8'hFF : ~(8'b1 << idx_q);
    segment_d = blanked ? BLANK_CODE : glyph;
    frame_done_d = wrap;
  end
  // state and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      shadow_q <= '0;
      pend_full_q <= 1'b0;
      ready_q <= 1'b0;
      digit_q <= 8'hFF;
      segment_q <= BLANK_CODE;
      frame_done_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      shadow_q <= shadow_d;
      pend_full_q <= pend_full_d;
      ready_q <= ready_d;
      digit_q <= digit_d;
      segment_q <= segment_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign bus.data_ready = ready_q;
  assign digit = digit_q;
  assign segment = segment_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed and random checks against a cycle-count reference model
module tb_seven_seg_scan_driver;
  localparam int DIV = 4;
  localparam int FRAME = DIV * 8;
  localparam logic [6:0] G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic blank_lz = 1'b0;
  logic [6:0] segment;
  logic [7:0] digit;
  logic frame_done;
  seven_seg_scan_driver_if bif ();
  seven_seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CODE(7'h7F)) dut (
    .clk(clk), .reset(reset), .bus(bif), .blank_lz(blank_lz),
    .segment(segment), .digit(digit), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_pend = '0;
  bit m_full = 0;
  bit m_ready = 0;
  logic [7:0] e_digit = 8'hFF;
  logic [6:0] e_seg = 7'h7F;
  logic e_fd = 1'b0;
  bit last_xfer = 0;
  int last_xfer_n = 0;
  function automatic int msd(input logic [31:0] w);
    for (int k = 7; k > 0; k--) if (w[4*k +: 4] != 4'h0) return k;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    int i;
    bit wrap, blanked;
    @(posedge clk);
    #1;
    last_xfer = 0;
    if (reset) begin
      n = 0; m_full = 0; m_shadow = '0; m_ready = 0;
      e_digit = 8'hFF; e_seg = 7'h7F; e_fd = 1'b0;
    end else begin
      i = (n / DIV) % 8;
      wrap = (n % FRAME) == FRAME - 1;
      blanked = blank_lz && i > msd(m_shadow);
      e_digit = blanked ? 8'hFF : ~(8'b1 << i);
      e_seg = blanked ? 7'h7F : G[m_shadow[4*i +: 4]];
      e_fd = wrap;
      if (bif.data_valid && m_ready) begin last_xfer = 1; last_xfer_n = n; end
      if (wrap && m_full) begin m_shadow = m_pend; m_full = 0; end
      if (last_xfer) begin m_pend = bif.data_in; m_full = 1; end
      m_ready = !m_full;
      n++;
    end
    chk("digit", digit, e_digit);
    chk("segment", segment, e_seg);
    chk("frame_done", frame_done, e_fd);
    chk("data_ready", bif.data_ready, m_ready);
  endtask
  task automatic send(input logic [31:0] w);
    int k;
    k = 0;
    bif.data_in = w;
    bif.data_valid = 1'b1;
    do begin step(); k++; end while (!last_xfer && k < 4 * FRAME);
    chk("send_accept", last_xfer, 1);
    bif.data_valid = 1'b0;
    bif.data_in = $urandom;
  endtask
  task automatic wait_frame();
    int k;
    k = 0;
    while (n % FRAME != 0 && k < 2 * FRAME) begin step(); k++; end
  endtask
  initial begin
    int lo, fd, ff;
    bif.data_valid = 1'b0;
    bif.data_in = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_digit", digit, 8'hFF);
      chk("rst_segment", segment, 7'h7F);
      chk("rst_ready", bif.data_ready, 0);
    end
    reset = 1'b0;
    step();
    chk("ready_after_rst", bif.data_ready, 1);
    send(32'h1234ABCD);
    wait_frame();
    lo = 0; fd = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (digit == 8'hFE) begin lo++; chk("d0_glyph", segment, 7'h21); end
      if (digit == 8'h7F) chk("d7_glyph", segment, 7'h79);
      if (frame_done) fd++;
    end
    chk("d0_slot_len", lo, DIV);
    chk("fd_per_frame", fd, 1);
    send(32'hCAFE0123);
    send(32'h0BADF00D);
    chk("second_after_wrap", last_xfer_n % FRAME, 0);
    for (int k = 0; k < 2 * FRAME; k++) step();
    blank_lz = 1'b1;
    send(32'h000000F0);
    wait_frame();
    ff = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (digit == 8'hFF) ff++;
      if (digit == 8'hFD) chk("lz_d1", segment, 7'h0E);
      if (digit == 8'hFE) chk("lz_d0", segment, 7'h40);
    end
    chk("lz_blank_slots", ff, 6 * DIV);
    send(32'h0);
    wait_frame();
    ff = 0;
    for (int k = 0; k < FRAME; k++) begin step(); if (digit == 8'hFF) ff++; end
    chk("zero_blank_slots", ff, 7 * DIV);
    while (n % FRAME != FRAME - 1) step();
    bif.data_in = 32'h87654329;
    bif.data_valid = 1'b1;
    step();
    chk("wrap_xfer", last_xfer, 1);
    chk("wrap_xfer_slot", last_xfer_n % FRAME, FRAME - 1);
    bif.data_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (digit == 8'hFE) chk("old_frame_d0", segment, 7'h40);
    end
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (digit == 8'hFE) chk("new_frame_d0", segment, 7'h10);
    end
    send(32'hDEADBEEF);
    for (int k = 0; k < 7; k++) step();
    reset = 1'b1;
    step();
    chk("midrst_digit", digit, 8'hFF);
    chk("midrst_segment", segment, 7'h7F);
    chk("midrst_ready", bif.data_ready, 0);
    step();
    reset = 1'b0;
    ff = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if (k == 0) chk("midrst_ready_up", bif.data_ready, 1);
      if (digit == 8'hFF) ff++;
      if (digit == 8'hFE) chk("midrst_d0", segment, 7'h40);
    end
    chk("midrst_pend_gone", ff, 14 * DIV);
    for (int k = 0; k < 1500; k++) begin
      blank_lz = $urandom_range(0, 1) == 1;
      if (!bif.data_valid && $urandom_range(0, 3) == 0) begin
        bif.data_valid = 1'b1;
        bif.data_in = $urandom >> $urandom_range(0, 31);
      end
      reset = $urandom_range(0, 399) == 0;
      step();
      if (last_xfer || reset) bif.data_valid = 1'b0;
      if (!bif.data_valid) bif.data_in = $urandom;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
